// File: rtl/core_ctrl_pkg.sv
// Shared control encodings for the multi-cycle core: opcodes, FSM states,
// immediate-format selects and ALU operation selects.
package core_ctrl_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_SB = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [1:0] IMM_SEL_I    = 2'b00;
    localparam logic [1:0] IMM_SEL_S    = 2'b01;
    localparam logic [1:0] IMM_SEL_SB   = 2'b10;
    localparam logic [1:0] IMM_SEL_NONE = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
               (op == OP_S) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/ctrl_mem_timeout.sv
// Memory wait counter: counts consecutive stalled cycles in FETCH/MEM and flags
// the cycle on which the wait limit is reached. MEM_TIMEOUT = 0 disables the trap.
module ctrl_mem_timeout #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = (MEM_TIMEOUT > 0) ? W'(MEM_TIMEOUT - 1) : '0;

    logic [W-1:0] cnt_q, cnt_d;
    logic         stall;

    // Any cycle that is not a stall clears the count, so each FETCH/MEM entry starts at 0.
    always_comb begin
        stall = waiting && !mem_ready;
        cnt_d = stall ? cnt_q + W'(1) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && stall && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing with memory timeout trap.
// Optional PERF_COUNT_EN macro adds cycle_count and instr_retired outputs.
module multicycle_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_sel,
    output logic             illegal,
`ifdef PERF_COUNT_EN
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired,
`endif
    output logic [2:0]       state_o
);

    state_e     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       waiting;
    logic       timeout;
    logic       retire;
    logic       unused_instr;

    assign unused_instr = ^instr[31:7];
    assign waiting      = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign state_o      = state_q;

    ctrl_mem_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .waiting  (waiting),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_OP_ADD;
        imm_sel    = IMM_SEL_NONE;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end

            // Opcode is captured here; later states never look at the IR again.
            ST_DECODE: begin
                op_d    = instr[6:0];
                state_d = is_legal_op(instr[6:0]) ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op  = ALU_OP_FUNCT;
                        state_d = ST_WB;
                    end
                    OP_I: begin
                        alu_op  = ALU_OP_FUNCT;
                        alu_src = 1'b1;
                        imm_sel = IMM_SEL_I;
                        state_d = ST_WB;
                    end
                    OP_LW: begin
                        alu_src = 1'b1;
                        imm_sel = IMM_SEL_I;
                        state_d = ST_MEM;
                    end
                    OP_S: begin
                        alu_src = 1'b1;
                        imm_sel = IMM_SEL_S;
                        state_d = ST_MEM;
                    end
                    OP_SB: begin
                        alu_op   = ALU_OP_SUB;
                        imm_sel  = IMM_SEL_SB;
                        pc_write = zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end

            // Address operands stay as in EXEC so the address is stable while waiting.
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_S);
                alu_src = 1'b1;
                imm_sel = (op_q == OP_S) ? IMM_SEL_S : IMM_SEL_I;
                if (mem_ready) begin
                    retire  = (op_q == OP_S);
                    state_d = (op_q == OP_S) ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_TRAP: illegal = 1'b1;

            default: state_d = ST_TRAP;
        endcase
    end

`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instr_retired_q, instr_retired_d;

    always_comb begin
        cycle_count_d   = (state_q != ST_TRAP) ? cycle_count_q + CNT_W'(1) : cycle_count_q;
        instr_retired_d = retire ? instr_retired_q + CNT_W'(1) : instr_retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q   <= '0;
            instr_retired_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instr_retired_q <= instr_retired_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign instr_retired = instr_retired_q;
`else
    logic unused_retire;
    localparam int UNUSED_CNT_W = CNT_W;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected cycle traces built
// from the instruction-class rules, replayed against the DUT with random don't-care inputs.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7;

    localparam logic [6:0] OPC_R = 7'h33, OPC_I = 7'h13, OPC_LW = 7'h03,
                           OPC_S = 7'h23, OPC_SB = 7'h63;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src;
    logic        reg_write, mem_to_reg, alu_src, illegal;
    logic [1:0]  alu_op, imm_sel;
    logic [2:0]  state_o;
`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] cycle_count, instr_retired;
`endif

    logic [15:0] obs;
    logic [15:0] exp_q[$];
    logic [33:0] stim_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          model_cycles = 0;
    int          model_retired = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .imm_sel      (imm_sel),
        .illegal      (illegal),
`ifdef PERF_COUNT_EN
        .cycle_count  (cycle_count),
        .instr_retired(instr_retired),
`endif
        .state_o      (state_o)
    );

    assign obs = {state_o, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
                  mem_to_reg, alu_src, alu_op, imm_sel, illegal};

    // ---------------- reference model ----------------
    function automatic logic [15:0] mk(input logic [2:0] st, input logic mreq, input logic mwe,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic rw, input logic m2r, input logic asrc,
                                       input logic [1:0] aop, input logic [1:0] isel,
                                       input logic ill);
        return {st, mreq, mwe, irw, pcw, pcs, rw, m2r, asrc, aop, isel, ill};
    endfunction

    function automatic logic [15:0] idle_vec();
        return mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0);
    endfunction

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    function automatic logic legal_op(input logic [6:0] op);
        return op == OPC_R || op == OPC_I || op == OPC_LW || op == OPC_S || op == OPC_SB;
    endfunction

    task automatic push(input logic rdy, input logic z, input logic [31:0] ins, input logic [15:0] e);
        stim_q.push_back({rdy, z, ins});
        exp_q.push_back(e);
        if (e[15:13] != S_TRAP) model_cycles++;
    endtask

    task automatic push_idle();
        push(rb(), rb(), $urandom(), idle_vec());
    endtask

    task automatic push_fetch(input int fw);
        for (int i = 0; i <= fw; i++) begin
            logic r;
            r = (i == fw);
            push(r, rb(), $urandom(), mk(S_FETCH, 1, 0, r, r, 0, 0, 0, 0, 2'b00, 2'b11, 0));
        end
    endtask

    task automatic push_decode(input logic [31:0] ins);
        push(rb(), rb(), ins, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0));
    endtask

    task automatic push_exec(input logic [31:0] ins, input logic z);
        logic [15:0] e;
        case (ins[6:0])
            OPC_R:   e = mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b11, 0);
            OPC_I:   e = mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
            OPC_LW:  e = mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
            OPC_S:   e = mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0);
            default: begin
                e = mk(S_EXEC, 0, 0, 0, z, 1, 0, 0, 0, 2'b01, 2'b10, 0);
                model_retired++;
            end
        endcase
        push(rb(), z, $urandom(), e);
    endtask

    task automatic push_mem(input logic [31:0] ins, input int mw);
        logic is_s;
        is_s = (ins[6:0] == OPC_S);
        for (int i = 0; i <= mw; i++) begin
            logic r;
            r = (i == mw);
            push(r, rb(), $urandom(),
                 mk(S_MEM, 1, is_s, 0, 0, 0, 0, 0, 1, 2'b00, is_s ? 2'b01 : 2'b00, 0));
        end
        if (is_s) model_retired++;
    endtask

    task automatic push_wb(input logic [31:0] ins);
        push(rb(), rb(), $urandom(),
             mk(S_WB, 0, 0, 0, 0, 0, 1, ins[6:0] == OPC_LW, 0, 2'b00, 2'b11, 0));
        model_retired++;
    endtask

    task automatic push_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
        push_fetch(fw);
        push_decode(ins);
        push_exec(ins, z);
        if (ins[6:0] == OPC_LW || ins[6:0] == OPC_S) push_mem(ins, mw);
        if (ins[6:0] != OPC_S && ins[6:0] != OPC_SB) push_wb(ins);
    endtask

    task automatic push_trap(input int n);
        for (int i = 0; i < n; i++)
            push(rb(), rb(), $urandom(), mk(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1));
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        instr = '0;
        stim_q.delete();
        exp_q.delete();
        model_cycles = 0;
        model_retired = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(output logic [15:0] got, output logic [15:0] want);
        logic [33:0] s;
        s = stim_q.pop_front();
        want = exp_q.pop_front();
        {mem_ready, zero, instr} = s;
        @(negedge clk);
        got = obs;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        instr = '0;
        #2;
        tests_run++;
        if (obs !== idle_vec()) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", obs, idle_vec());
        end
`ifdef PERF_COUNT_EN
        tests_run++;
        if (cycle_count !== '0 || instr_retired !== '0) begin
            tests_failed++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", cycle_count, instr_retired);
        end
`endif
        do_reset();
    endtask

    task automatic test_directed();
        logic [15:0] got, want;
        int idx;
        do_reset();
        push_idle();
        push_instr(32'h002081B3, 0, 0, 1'b0);
        push_instr(32'h0000A103, 0, 3, 1'b0);
        push_instr(32'h00208463, 0, 0, 1'b1);
        push_instr(32'h00208463, 0, 0, 1'b0);
        push_instr(32'h0020A023, 0, 0, 1'b0);
        push_instr(32'h00500093, 1, 0, 1'b0);
        push_fetch(0);
        idx = 0;
        while (exp_q.size() > 0) begin
            step(got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL directed cycle %0d: got %h expected %h", idx, got, want);
            end
            idx++;
        end
    endtask

    task automatic test_random();
        logic [15:0] got, want;
        logic [6:0]  ops [5];
        int idx;
        ops = '{OPC_R, OPC_I, OPC_LW, OPC_S, OPC_SB};
        do_reset();
        push_idle();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, 4)];
            push_instr(ins, $urandom_range(0, 4), $urandom_range(0, 4), rb());
        end
        push_fetch(0);
        idx = 0;
        while (exp_q.size() > 0) begin
            step(got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got %h expected %h", idx, got, want);
            end
            idx++;
        end
`ifdef PERF_COUNT_EN
        tests_run++;
        if (cycle_count !== CNT_W'(model_cycles) || instr_retired !== CNT_W'(model_retired)) begin
            tests_failed++;
            $display("FAIL random_perf: got %0d/%0d expected %0d/%0d",
                     cycle_count, instr_retired, model_cycles, model_retired);
        end
`endif
    endtask

    task automatic test_illegal();
        logic [15:0] got, want;
        logic [31:0] bad;
        int idx;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            bad = 32'h0000007F;
            if (pass == 1) begin
                bad = $urandom();
                while (legal_op(bad[6:0])) bad = $urandom();
            end
            push_idle();
            push_fetch(1);
            push_decode(bad);
            push_trap(6);
            idx = 0;
            while (exp_q.size() > 0) begin
                step(got, want);
                tests_run++;
                if (got !== want) begin
                    tests_failed++;
                    $display("FAIL illegal%0d cycle %0d: got %h expected %h", pass, idx, got, want);
                end
                idx++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] got, want;
        int idx;
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            push_idle();
            if (sc == 0) begin
                for (int i = 0; i < MEM_TIMEOUT; i++)
                    push(1'b0, rb(), $urandom(), mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0));
                push_trap(4);
            end else if (sc == 1) begin
                push_instr(32'h0000A103, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0);
                push_fetch(0);
            end else begin
                push_fetch(0);
                push_decode(32'h0020A023);
                push_exec(32'h0020A023, 1'b0);
                for (int i = 0; i < MEM_TIMEOUT; i++)
                    push(1'b0, rb(), $urandom(), mk(S_MEM, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0));
                push_trap(3);
            end
            idx = 0;
            while (exp_q.size() > 0) begin
                step(got, want);
                tests_run++;
                if (got !== want) begin
                    tests_failed++;
                    $display("FAIL timeout%0d cycle %0d: got %h expected %h", sc, idx, got, want);
                end
                idx++;
            end
`ifdef PERF_COUNT_EN
            tests_run++;
            if (cycle_count !== CNT_W'(model_cycles) || instr_retired !== CNT_W'(model_retired)) begin
                tests_failed++;
                $display("FAIL timeout%0d_perf: got %0d/%0d expected %0d/%0d",
                         sc, cycle_count, instr_retired, model_cycles, model_retired);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [15:0] got, want, mem_vec;
        int idx;
        do_reset();
        push_idle();
        push_fetch(0);
        push_decode(32'h0000A103);
        push_exec(32'h0000A103, 1'b0);
        idx = 0;
        while (exp_q.size() > 0) begin
            step(got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL mid_mem_setup cycle %0d: got %h expected %h", idx, got, want);
            end
            idx++;
        end
        mem_ready = 1'b0;
        #1;
        mem_vec = mk(S_MEM, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
        tests_run++;
        if (obs !== mem_vec) begin
            tests_failed++;
            $display("FAIL mid_mem_state: got %h expected %h", obs, mem_vec);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (obs !== idle_vec()) begin
            tests_failed++;
            $display("FAIL mid_mem_async_reset: got %h expected %h", obs, idle_vec());
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs !== idle_vec()) begin
            tests_failed++;
            $display("FAIL mid_mem_reset_held: got %h expected %h", obs, idle_vec());
        end
`ifdef PERF_COUNT_EN
        tests_run++;
        if (cycle_count !== '0 || instr_retired !== '0) begin
            tests_failed++;
            $display("FAIL mid_mem_perf: got %0d/%0d expected 0/0", cycle_count, instr_retired);
        end
`endif
        reset = 1'b0;
    endtask

`ifdef PERF_COUNT_EN
    task automatic test_perf();
        logic [15:0] got, want;
        int idx;
        do_reset();
        push_idle();
        for (int n = 0; n < 3; n++) push_instr(32'h002081B3, 0, 0, 1'b0);
        idx = 0;
        while (exp_q.size() > 0) begin
            step(got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL perf cycle %0d: got %h expected %h", idx, got, want);
            end
            idx++;
        end
        tests_run++;
        if (cycle_count !== CNT_W'(13) || instr_retired !== CNT_W'(3)) begin
            tests_failed++;
            $display("FAIL perf_three_r: got %0d/%0d expected 13/3", cycle_count, instr_retired);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
`ifdef PERF_COUNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
